// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state encoding, idle line levels and column priority helper
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'hF;
    localparam logic [3:0] COL_NONE = 4'hF;

    // index of the lowest column pulled low; only called with at least one low bit
    function automatic logic [1:0] low_col(input logic [3:0] c);
        return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines plus the decoded key event
interface keypad_scan_if;

    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (input col, output row, key_valid, key_code, key_held);
    modport slave  (output col, input row, key_valid, key_code, key_held);

endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer for the asynchronous column inputs
module keypad_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] s1_q, s1_d, s2_q, s2_d;

    // shift the raw column sample one stage deeper each cycle
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // both stages idle at "no column low" out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= COL_NONE;
            s2_q <= COL_NONE;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad row scanner with debounce; define KEYPAD_REPEAT_EN for auto-repeat while held
module keypad_scan
    import keypad_pkg::*;
#(
    parameter logic [19:0] CNT_MAX    = 20'd1_000_000,
    parameter logic [15:0] SCAN_DIV   = 16'd50_000,
    parameter logic [23:0] REPEAT_MAX = 24'd10_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_scan_if.master  bus
);

    localparam int CW = $bits(CNT_MAX);
    localparam int DW = $bits(SCAN_DIV);

    state_t        state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic [3:0]    col_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $bits(REPEAT_MAX);
    logic [RW-1:0] rpt_q, rpt_d;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_MAX;
`endif

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.col),
        .q     (col_s)
    );

    // next state: scan rows, confirm a stable pattern, track hold and a stable release
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        code_d    = code_q;
        valid_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d     = '0;
`endif
        case (state_q)
            SCAN: begin
                cnt_d = '0;
                if (div_q == SCAN_DIV - 1'b1) begin
                    div_d = '0;
                    if (col_s != COL_NONE) begin
                        pat_d   = col_s;
                        state_d = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s != pat_q) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == CNT_MAX - 1'b1) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    code_d  = {row_idx_q, low_col(pat_q)};
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (col_s == COL_NONE) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rpt_q == REPEAT_MAX - 1'b1) begin
                    valid_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (col_s != COL_NONE) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == CNT_MAX - 1'b1) begin
                    cnt_d     = '0;
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // state and counter registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            row_idx_q <= 2'd0;
            div_q     <= '0;
            cnt_q     <= '0;
            pat_q     <= COL_NONE;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign bus.row       = ROW_IDLE & ~(4'b0001 << row_idx_q);
    assign bus.key_valid = valid_q;
    assign bus.key_code  = code_q;
    assign bus.key_held  = (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and random key presses checked against a cycle model of the keypad rules
module tb_keypad_scan;

    localparam int CM = 10;
    localparam int SD = 4;
    localparam int RM = 30;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif
    localparam int M_SCAN = 0, M_CONFIRM = 1, M_HELD = 2, M_REL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = '0;
    int          n_cmp = 0, n_bad = 0, pulses = 0;

    keypad_scan_if bus();

    keypad_scan #(.CNT_MAX(20'd10), .SCAN_DIV(16'd4), .REPEAT_MAX(24'd30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         m_mode = M_SCAN, m_row = 0, m_dwell = 0, m_run = 0, m_rpt = 0;
    logic [3:0] m_pat = 4'hF, m_code = 4'h0, m_s1 = 4'hF, m_s2 = 4'hF;
    logic       m_valid = 1'b0;

    function automatic int first_low(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    // physical matrix: a pressed key on a driven row pulls its column low
    function automatic logic [3:0] keypad(input logic [3:0] r, input logic [15:0] p);
        logic [3:0] c = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!r[i] && p[i*4+j]) c[j] = 1'b0;
        return c;
    endfunction

    task automatic model_edge(input logic [3:0] c, input logic rn);
        logic [3:0] cs;
        cs = m_s2;
        m_valid = 1'b0;
        if (!rn) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_mode = M_SCAN; m_row = 0; m_dwell = 0;
            m_run = 0; m_rpt = 0; m_code = 4'h0; m_pat = 4'hF;
            return;
        end
        m_s2 = m_s1;
        m_s1 = c;
        if (m_mode == M_SCAN) begin
            m_dwell++;
            if (m_dwell == SD) begin
                m_dwell = 0;
                if (cs != 4'hF) begin m_pat = cs; m_run = 0; m_mode = M_CONFIRM; end
                else m_row = (m_row + 1) % 4;
            end
        end else if (m_mode == M_CONFIRM) begin
            if (cs != m_pat) begin m_mode = M_SCAN; m_run = 0; end
            else begin
                m_run++;
                if (m_run == CM) begin
                    m_valid = 1'b1; m_code = 4'(m_row * 4 + first_low(m_pat));
                    m_mode = M_HELD; m_run = 0; m_rpt = 0;
                end
            end
        end else if (m_mode == M_HELD) begin
            if (cs == 4'hF) begin m_mode = M_REL; m_run = 0; m_rpt = 0; end
            else if (REPEAT) begin
                m_rpt++;
                if (m_rpt == RM) begin m_valid = 1'b1; m_rpt = 0; end
            end
        end else begin
            if (cs != 4'hF) begin m_mode = M_HELD; m_run = 0; end
            else begin
                m_run++;
                if (m_run == CM) begin m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_dwell = 0; m_run = 0; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [3:0] exp_row;
        @(posedge clk);
        model_edge(bus.col, rst_n);
        #1;
        if (bus.key_valid === 1'b1) pulses++;
        exp_row = ~(4'b0001 << m_row);
        chk("row", 8'(bus.row), 8'(exp_row));
        chk("key_valid", 8'(bus.key_valid), 8'(m_valid));
        chk("key_code", 8'(bus.key_code), 8'(m_code));
        chk("key_held", 8'(bus.key_held), 8'(m_mode >= M_HELD));
        @(negedge clk);
        bus.col = keypad(bus.row, pressed);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_pulse(input string tag);
        int t = 0;
        while (pulses == 0 && t < 80) begin cyc(); t++; end
        chk(tag, 8'(pulses != 0), 8'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_row", 8'(bus.row), 8'h0E);
        chk("rst_valid", 8'(bus.key_valid), 8'h00);
        chk("rst_code", 8'(bus.key_code), 8'h00);
        chk("rst_held", 8'(bus.key_held), 8'h00);
    endtask

    initial begin
        int offs[$];
        bus.col = 4'hF;
        run(3);
        chk_reset_outputs();
        rst_n = 1'b1;
        run(2);

        pressed = 16'(1 << 9); pulses = 0;
        run(40);
        chk("r028_pulses", 8'(pulses), 8'd1);
        chk("r028_code", 8'(bus.key_code), 8'h09);
        chk("r028_held", 8'(bus.key_held), 8'd1);
        pressed = '0;
        run(20);

        pulses = 0;
        foreach (offs[i]) offs.delete(i);
        for (int i = 0; i < 3; i++) begin
            pressed = 16'h1111;
            run(i == 0 ? 2 : i == 1 ? 4 : 3);
            pressed = '0;
            run(8);
            chk("r029_idle", 8'(bus.key_held), 8'd0);
        end
        chk("r029_pulses", 8'(pulses), 8'd0);

        pressed = 16'h0009; pulses = 0;
        wait_pulse("r031_timeout");
        chk("r031_code", 8'(bus.key_code), 8'h00);
        pressed = '0;
        run(20);

        pressed = 16'h0001; pulses = 0;
        wait_pulse("r030_timeout");
        run(3);
        pressed = '0;      run(5);
        chk("r030_bounce_hi", 8'(bus.key_held), 8'd1);
        pressed = 16'h0001; run(2);
        chk("r030_bounce_lo", 8'(bus.key_held), 8'd1);
        pressed = '0;      run(12);
        run(4);
        chk("r030_dropped", 8'(bus.key_held), 8'd0);
        chk("r030_pulses", 8'(pulses), 8'd1);
        run(10);

        pressed = 16'(1 << 6);
        begin
            int t = 0;
            while (!(m_mode == M_CONFIRM && m_run == 6) && t < 80) begin cyc(); t++; end
            chk("r032_reach", 8'(t < 80), 8'd1);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_reset_outputs();
        end
        rst_n = 1'b1; pulses = 0;
        run(12);
        chk("r032_no_early", 8'(pulses), 8'd0);
        wait_pulse("r032_timeout");
        chk("r032_code", 8'(bus.key_code), 8'h06);
        pressed = '0;
        run(20);

        pressed = 16'(1 << 5); pulses = 0;
        wait_pulse("r033_timeout");
        chk("r033_code", 8'(bus.key_code), 8'h05);
        for (int k = 1; k < 100; k++) begin
            cyc();
            if (bus.key_valid === 1'b1) offs.push_back(k);
        end
`ifdef KEYPAD_REPEAT_EN
        chk("r033_repeats", 8'(offs.size()), 8'd3);
        for (int i = 0; i < 3; i++)
            chk("r033_offset", 8'(i < offs.size() ? offs[i] : -1), 8'(30 * (i + 1)));
        chk("r033_code_end", 8'(bus.key_code), 8'h05);
`else
        chk("r025_repeats", 8'(offs.size()), 8'd0);
`endif
        pressed = '0;
        run(20);

        for (int n = 0; n < 30; n++) begin
            int k;
            k = int'($urandom_range(0, 15));
            pressed = 16'(1 << k);
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
            run(int'($urandom_range(1, 40)));
            if ($urandom_range(0, 1) == 1) begin
                pressed = '0;
                run(int'($urandom_range(1, 4)));
                pressed = 16'(1 << k);
                run(int'($urandom_range(1, 3)));
            end
            pressed = '0;
            run(int'($urandom_range(1, 40)));
        end
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter CNT_MAX, default 20'd1_000_000, debounce window in clk cycles (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter SCAN_DIV, default 16'd50_000, row dwell time in clk cycles; legal range 4..2^16-1.
REQ-003 Parameter REPEAT_MAX, default 24'd10_000_000, auto-repeat period in clk cycles; used only with KEYPAD_REPEAT_EN.
REQ-004 Port clk, input, 1, system clock; the block uses one clock domain only.
REQ-005 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 Port col, input, 4, keypad columns; active-low with external pull-ups; asynchronous to clk.
REQ-007 Port row, output, 4, row drive; active-low, one-hot-low.
REQ-008 Port key_valid, output, 1, one-cycle pulse for each accepted key event.
REQ-009 Port key_code, output, 4, code = row_idx*4 + col_idx; valid when key_valid=1 and held until the next event.
REQ-010 Port key_held, output, 1, high while the accepted key remains pressed.

Function
REQ-011 col SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value col_s.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-013 SCAN: row rotates 4'b1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
REQ-014 SCAN: col_s SHALL be sampled only in the last cycle of each dwell; if col_s != 4'hF, latch row_idx and col_s, freeze row, go to DEBOUNCE.
REQ-015 If several columns are low, the lowest-index low column SHALL be selected; several rows are never driven together.
REQ-016 DEBOUNCE: counter counts while col_s equals the latched pattern; any mismatch clears the counter and returns to SCAN with the row unchanged.
REQ-017 DEBOUNCE: when the counter reaches CNT_MAX-1, key_valid SHALL pulse for one cycle with key_code updated in the same cycle, and the FSM SHALL go to HOLD.
REQ-018 HOLD: key_held=1; row stays frozen; when col_s == 4'hF, go to RELEASE.
REQ-019 RELEASE: count CNT_MAX cycles of col_s == 4'hF, then go to SCAN at the next row; any low column returns to HOLD and clears the counter without emitting an event.
REQ-020 key_held SHALL be 1 in HOLD and RELEASE and 0 in SCAN and DEBOUNCE.
REQ-021 Counters SHALL saturate or clear and never wrap; counter width SHALL come from the parameter width.

Reset
REQ-022 With rst_n=0 at a clk edge: state=SCAN, row=4'b1110, key_valid=0, key_code=4'h0, key_held=0, synchronizer=4'hF, all counters=0.
REQ-023 Reset asserted mid-DEBOUNCE or mid-HOLD SHALL abort the event; no key_valid pulse is emitted after reset releases until a full new debounce completes.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in HOLD, after REPEAT_MAX cycles continuously held, key_valid SHALL pulse again with the same key_code, repeating every REPEAT_MAX cycles; the repeat counter clears on leaving HOLD.
REQ-025 KEYPAD_REPEAT_EN undefined: exactly one key_valid pulse per press; the repeat counter is not synthesized.

Structure
REQ-026 Package keypad_pkg SHALL hold the state encoding constants (2-bit), ROW_IDLE=4'hF and COL_NONE=4'hF.
REQ-027 The 2-flop synchronizer SHALL be sub-module keypad_sync (4 bits wide); the FSM and counters stay in keypad_scan.

Verification (CNT_MAX=10, SCAN_DIV=4, REPEAT_MAX=30)
REQ-028 Hold col=4'b1101 while row=4'b1011 for 20 cycles -> exactly one key_valid, key_code=4'h9, key_held=1.
REQ-029 Apply col low pulses of 2, 4 and 3 cycles separated by highs -> no key_valid, and the FSM returns to SCAN each time.
REQ-030 Press key 0, then bounce on release (high 5, low 2, high 12) -> a single key_valid; key_held drops only after 10 stable-high cycles.
REQ-031 Drive col=4'b0110 on row 0 -> key_code=4'h0 (lowest column wins).
REQ-032 Assert rst_n=0 at DEBOUNCE count 6, release, and keep the key pressed -> no pulse before a fresh 10-cycle debounce; outputs hold reset values while reset is active.
REQ-033 With KEYPAD_REPEAT_EN, hold key 5 for 100 cycles after acceptance -> key_valid at acceptance and at +30, +60 and +90, all with key_code=4'h5.
